// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI monarch between port 0 (inertial) and port 1 (A2D).
// Optional macro SPI_ARB_TIMEOUT_EN adds a WAIT watchdog with a timeout_err pulse.
module spi_arbiter #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] cmd0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic [15:0] resp0,
    output logic        done1,
    output logic [15:0] resp1,
    output logic        mnrch_wrt,
    output logic [15:0] mnrch_cmd,
    input  logic        mnrch_done,
    input  logic [15:0] mnrch_resp,
    output logic        sel,
    output logic        busy,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic [1:0]  state_dbg
);
    // Handshake: reqN is a level held until doneN; doneN is a one-cycle pulse with respN valid.
    // mnrch_wrt is a one-cycle start; mnrch_resp is taken only when mnrch_done pulses in WAIT.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, GAP = 2'd3} state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_t AFTER_WAIT = (GAP_CYCLES == 0) ? IDLE : GAP;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t        state;
    logic          last;
    logic [GW-1:0] gap_cnt;
    logic          grant_any;
    logic          grant_port;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wait_cnt;
`endif

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_any  = req0 | req1;
        grant_port = (req0 & req1) ? ~last : req1;
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            sel       <= 1'b0;
            mnrch_cmd <= '0;
            mnrch_wrt <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            resp0     <= '0;
            resp1     <= '0;
            gap_cnt   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            mnrch_wrt <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sel       <= grant_port;
                        last      <= grant_port;
                        mnrch_cmd <= grant_port ? cmd1 : cmd0;
                        mnrch_wrt <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (mnrch_done) begin
                        if (sel) begin
                            resp1 <= mnrch_resp;
                            done1 <= 1'b1;
                        end else begin
                            resp0 <= mnrch_resp;
                            done0 <= 1'b1;
                        end
                        gap_cnt <= '0;
                        state   <= AFTER_WAIT;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        if (sel) begin
                            resp1 <= 16'hFFFF;
                            done1 <= 1'b1;
                        end else begin
                            resp0 <= 16'hFFFF;
                            done0 <= 1'b1;
                        end
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= AFTER_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios plus randomized two-port traffic
// against a timestamp-based reference model; define SPI_ARB_TIMEOUT_EN to cover the watchdog.
module tb_spi_arbiter;
    localparam int G  = 4;
    localparam int TO = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] cmd0 = '0, cmd1 = '0;
    logic        mnrch_done = 1'b0;
    logic [15:0] mnrch_resp = '0;
    logic        done0, done1, mnrch_wrt, sel, busy;
    logic [15:0] resp0, resp1, mnrch_cmd;
    logic [1:0]  state_dbg;
`ifdef SPI_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    spi_arbiter #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
        .done0(done0), .resp0(resp0), .done1(done1), .resp1(resp1),
        .mnrch_wrt(mnrch_wrt), .mnrch_cmd(mnrch_cmd),
        .mnrch_done(mnrch_done), .mnrch_resp(mnrch_resp),
        .sel(sel), .busy(busy),
`ifdef SPI_ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .state_dbg(state_dbg)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // monarch model: answers each start after a delay, optionally silent or with stray pulses
    int          mon_cd = 0;
    bit          mon_silent = 0;
    bit          mon_fix = 0;
    bit          stray_en = 0;
    logic [15:0] mon_fix_resp = 16'h1234;

    always @(negedge clk) begin
        mnrch_done = 1'b0;
        mnrch_resp = 16'($urandom);
        if (rst) begin
            mon_cd = 0;
        end else if (mnrch_wrt && !mon_silent) begin
            mon_cd = mon_fix ? 5 : $urandom_range(1, 8);
        end else if (mon_cd > 0) begin
            mon_cd--;
            if (mon_cd == 0) begin
                mnrch_done = 1'b1;
                if (mon_fix) mnrch_resp = mon_fix_resp;
            end
        end else if (stray_en && $urandom_range(0, 15) == 0) begin
            mnrch_done = 1'b1;
        end
    end

    // reference model: tracks grant/completion edges and the earliest next-grant edge
    int          e = 0;
    bit          m_busy, m_last, m_port;
    int          m_grant_e, m_gap_end;
    logic        x_wrt, x_done0, x_done1, x_sel, x_busy, x_to;
    logic [15:0] x_resp0, x_resp1, x_cmd;

    task automatic model_complete(input logic [15:0] r, input bit to);
        if (m_port) begin x_done1 = 1'b1; x_resp1 = r; end
        else begin x_done0 = 1'b1; x_resp0 = r; end
        x_to = to;
        m_busy = 1'b0;
        m_gap_end = e + G;
    endtask

    always @(posedge clk) begin
        e++;
        x_wrt = 1'b0; x_done0 = 1'b0; x_done1 = 1'b0; x_to = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_gap_end = e;
            x_resp0 = '0; x_resp1 = '0; x_sel = 1'b0; x_cmd = '0;
        end else if (m_busy) begin
            if (e >= m_grant_e + 2 && mnrch_done) model_complete(mnrch_resp, 1'b0);
`ifdef SPI_ARB_TIMEOUT_EN
            else if (e == m_grant_e + 1 + TO) model_complete(16'hFFFF, 1'b1);
`endif
        end else if (e > m_gap_end && (req0 || req1)) begin
            m_port = (req0 && req1) ? !m_last : req1;
            m_last = m_port;
            m_busy = 1'b1;
            m_grant_e = e;
            x_wrt = 1'b1;
            x_sel = m_port;
            x_cmd = m_port ? cmd1 : cmd0;
        end
        x_busy = m_busy || (e < m_gap_end);
    end

    // scoreboard: per-cycle output compare plus expected grant order
    logic [16:0] exp_q[$];
    bit chk_en = 0, gap_chk = 0;
    int cyc = 0, wrt_cnt = 0, done_cnt0 = 0, done_cnt1 = 0, last_done_cyc = -1;
    logic [15:0] last_wrt_cmd;
    logic        last_wrt_sel;

    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            check("wrt", 32'(mnrch_wrt), 32'(x_wrt));
            check("done0", 32'(done0), 32'(x_done0));
            check("done1", 32'(done1), 32'(x_done1));
            check("resp0", 32'(resp0), 32'(x_resp0));
            check("resp1", 32'(resp1), 32'(x_resp1));
            check("sel", 32'(sel), 32'(x_sel));
            check("cmd", 32'(mnrch_cmd), 32'(x_cmd));
            check("busy", 32'(busy), 32'(x_busy));
`ifdef SPI_ARB_TIMEOUT_EN
            check("timeout_err", 32'(timeout_err), 32'(x_to));
`endif
            if (mnrch_wrt) begin
                wrt_cnt++;
                last_wrt_cmd = mnrch_cmd;
                last_wrt_sel = sel;
                if (exp_q.size() > 0) check("order", 32'({sel, mnrch_cmd}), 32'(exp_q.pop_front()));
                if (gap_chk && last_done_cyc >= 0) check("gap", 32'(cyc - last_done_cyc), 32'(G + 1));
            end
            if (done0) begin done_cnt0++; last_done_cyc = cyc; end
            if (done1) begin done_cnt1++; last_done_cyc = cyc; end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic sig_now(input int which);
        case (which)
            0:       return done0;
            1:       return done1;
            default: return mnrch_wrt;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int budget, input string tag);
        int k = 0;
        while (k < budget && !sig_now(which)) begin
            step(1);
            k++;
        end
        check(tag, 32'(sig_now(which)), 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
    endtask

    task automatic port_proc(input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 6));
            if (p) begin cmd1 = 16'($urandom); req1 = 1'b1; end
            else begin cmd0 = 16'($urandom); req0 = 1'b1; end
            if ($urandom_range(0, 7) == 0) step(1);
            else wait_sig(p ? 1 : 0, 300, p ? "rand_done1" : "rand_done0");
            if (p) req1 = 1'b0; else req0 = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0, d1, w0;
        // 1: reset then idle
        @(posedge clk);
        chk_en = 1;
        step(1);
        rst = 1'b0;
        step(20);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_wrt_cnt", 32'(wrt_cnt), 32'd0);
        check("idle_state", 32'(state_dbg), 32'd0);

        // 2: single port 0 transaction
        mon_fix = 1;
        cmd0 = 16'hA5D0;
        req0 = 1'b1;
        wait_sig(0, 50, "t2_done0");
        req0 = 1'b0;
        check("t2_resp0", 32'(resp0), 32'h1234);
        check("t2_cmd", 32'(last_wrt_cmd), 32'hA5D0);
        check("t2_sel", 32'(last_wrt_sel), 32'd0);
        check("t2_wrt_cnt", 32'(wrt_cnt), 32'd1);
        check("t2_done1_cnt", 32'(done_cnt1), 32'd0);
        step(10);

        // 3: simultaneous requests from reset alternate with a fixed gap
        do_reset(2);
        cmd0 = 16'h0C0C;
        cmd1 = 16'h1D1D;
        exp_q.push_back({1'b0, 16'h0C0C});
        exp_q.push_back({1'b1, 16'h1D1D});
        exp_q.push_back({1'b0, 16'h0C0C});
        exp_q.push_back({1'b1, 16'h1D1D});
        last_done_cyc = -1;
        gap_chk = 1;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) step(1);
        req0 = 1'b0;
        req1 = 1'b0;
        check("t3_order_left", 32'(exp_q.size()), 32'd0);
        wait_sig(1, 50, "t3_last_done1");
        gap_chk = 0;
        step(10);

        // 4a: port 1 pulses only during GAP
        req0 = 1'b1;
        cmd0 = 16'h4444;
        wait_sig(0, 50, "t4_done0");
        req0 = 1'b0;
        req1 = 1'b1;
        w0 = wrt_cnt;
        step(1);
        req1 = 1'b0;
        step(20);
        check("t4_no_port1", 32'(wrt_cnt), 32'(w0));
        // 4b: port 0 drops during WAIT
        req0 = 1'b1;
        wait_sig(2, 20, "t4_wrt");
        step(2);
        req0 = 1'b0;
        wait_sig(0, 20, "t4_late_done0");
        step(10);

        // 5: reset mid-WAIT abandons the transaction
        req0 = 1'b1;
        wait_sig(2, 20, "t5_wrt");
        d0 = done_cnt0;
        d1 = done_cnt1;
        step(2);
        rst = 1'b1;
        req0 = 1'b0;
        step(1);
        rst = 1'b0;
        check("t5_state", 32'(state_dbg), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        step(8);
        check("t5_no_done", 32'(done_cnt0 + done_cnt1), 32'(d0 + d1));
        cmd1 = 16'h5A5A;
        req1 = 1'b1;
        wait_sig(1, 50, "t5_done1");
        req1 = 1'b0;
        check("t5_sel", 32'(sel), 32'd1);
        step(10);
        mon_fix = 0;

        // 6: monarch never answers
        mon_silent = 1;
        req0 = 1'b1;
        wait_sig(2, 20, "t6_wrt");
        c0 = cyc;
        d0 = done_cnt0;
`ifdef SPI_ARB_TIMEOUT_EN
        wait_sig(0, 40, "t6_to_done0");
        check("t6_to_latency", 32'(cyc - c0), 32'(TO + 1));
        check("t6_to_resp0", 32'(resp0), 32'hFFFF);
        check("t6_to_err", 32'(timeout_err), 32'd1);
        req0 = 1'b0;
`else
        step(1100);
        check("t6_hang_busy", 32'(busy), 32'd1);
        check("t6_hang_no_done", 32'(done_cnt0), 32'(d0));
        req0 = 1'b0;
        do_reset(1);
`endif
        mon_silent = 0;
        step(10);

        // random traffic with stray monarch pulses
        do_reset(1);
        stray_en = 1;
        fork
            port_proc(1'b0, 60);
            port_proc(1'b1, 60);
        join
        step(20);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
